// File: rtl/shift_pkg.sv
// Shared definitions for the shift functional units (left and right shifters).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: operand/shift-amount widths, step counter width, FSM state enum.
package shift_pkg;

  localparam int XLEN    = 64;
  localparam int SHAMT_W = 6;
  localparam int STEP_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sll_seq_if.sv
// Operand/result handshake bundle for the sequential left shifter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the operand and the result side.
// Ports: in_valid/in_ready/a/n/word toward the unit, out_valid/out_ready/result back.
interface shift_sll_seq_if #(
  parameter int XLEN    = shift_pkg::XLEN,
  parameter int SHAMT_W = shift_pkg::SHAMT_W
);

  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    a;
  logic [SHAMT_W-1:0] n;
  logic               word;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    result;

  // Producer/consumer side (EX-stage issue logic).
  modport master (
    output in_valid, a, n, word, out_ready,
    input  in_ready, out_valid, result
  );

  // Functional-unit side.
  modport slave (
    input  in_valid, a, n, word, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/sll_stage.sv
// One conditional power-of-two left-shift stage; shift distance is 2^step_i.
// Latency: combinational.
// Backpressure: none.
// Ports: acc_i value in, step_i stage index (0..5), en_i apply-shift, acc_o value out.
module sll_stage
  import shift_pkg::*;
(
  input  logic [XLEN-1:0]   acc_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              en_i,
  output logic [XLEN-1:0]   acc_o
);

  always_comb begin
    acc_o = acc_i;
    if (en_i) begin
      case (step_i)
        3'd0:    acc_o = acc_i << 1;
        3'd1:    acc_o = acc_i << 2;
        3'd2:    acc_o = acc_i << 4;
        3'd3:    acc_o = acc_i << 8;
        3'd4:    acc_o = acc_i << 16;
        3'd5:    acc_o = acc_i << 32;
        default: acc_o = acc_i;
      endcase
    end
  end

endmodule

// File: rtl/shift_sll_seq.sv
// Multi-cycle 64-bit logical left shifter (SLL/SLLI/SLLW/SLLIW), one binary stage per clock.
// Latency: 6 cycles from accept edge to out_valid, independent of the shift amount.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts.
// Ports: clk, rst_n (async active-low), flush (sync abort), bus (slave side of shift_sll_seq_if).
module shift_sll_seq #(
  parameter int XLEN    = 64,  // only 64 is supported
  parameter int SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  shift_sll_seq_if.slave   bus
);

  import shift_pkg::state_e;
  import shift_pkg::IDLE;
  import shift_pkg::BUSY;
  import shift_pkg::DONE;
  import shift_pkg::STEP_W;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     acc_q, acc_d;
  logic [SHAMT_W-1:0]  amt_q, amt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                word_q, word_d;

  logic [XLEN-1:0]     acc_sh;
  logic                stage_en;

  // Bit of the shift amount that governs the current stage.
  assign stage_en = |(amt_q & (SHAMT_W'(1) << step_q));

  sll_stage u_stage (
    .acc_i  (acc_q),
    .step_i (step_q),
    .en_i   (stage_en),
    .acc_o  (acc_sh)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    step_d  = step_q;
    word_d  = word_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && !flush) begin
          acc_d  = bus.a;
          amt_d  = bus.n;
          // W-forms shift by n mod 32: the 32-bit stage is never applied.
          if (bus.word) amt_d[SHAMT_W-1] = 1'b0;
          word_d  = bus.word;
          step_d  = STEP_W'(SHAMT_W - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_sh;
        if (step_q == '0) begin
          state_d = DONE;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Squash wins over accept and over the result handshake.
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      step_q  <= '0;
      word_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      step_q  <= step_d;
      word_q  <= word_d;
    end
  end

  // Outputs decode registered state only; no combinational path from out_ready.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = word_q ? {{(XLEN-32){acc_q[31]}}, acc_q[31:0]} : acc_q;

endmodule
